// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one SPI master core between REQ_COUNT requesters.
// Each grant runs one full transaction (config, start, watchdog wait, response).
module spi_txn_arbiter #(
  parameter int REQ_COUNT        = 4,
  parameter int SLAVE_COUNT      = 1,
  parameter int MAX_PACKAGE_SIZE = 8,
  parameter int TIMEOUT_CYCLES   = 4096,
  localparam int DW = 8 * MAX_PACKAGE_SIZE,
  localparam int SW = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1,
  localparam int ZW = $clog2(MAX_PACKAGE_SIZE + 1),
  localparam int RW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [REQ_COUNT-1:0]    req_valid,
  output logic [REQ_COUNT-1:0]    req_ready,
  input  logic [REQ_COUNT*SW-1:0] req_slave,
  input  logic [REQ_COUNT*ZW-1:0] req_size,
  input  logic [REQ_COUNT*2-1:0]  req_mode,
  input  logic [REQ_COUNT*DW-1:0] req_data,
  output logic [REQ_COUNT-1:0]    rsp_valid,
  input  logic [REQ_COUNT-1:0]    rsp_ready,
  output logic [DW-1:0]           rsp_data,
  output logic                    rsp_err,
  output logic [SW-1:0]           core_slave,
  output logic [ZW-1:0]           core_size,
  output logic [1:0]              core_mode,
  output logic [DW-1:0]           core_tx_data,
  output logic                    core_start,
  output logic                    core_abort,
  input  logic                    core_busy,
  input  logic                    core_done,
  input  logic [DW-1:0]           core_rx_data,
  output logic                    busy,
  output logic [RW-1:0]           grant_id
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, RESP} state_t;

  state_t        state;
  logic [RW-1:0] ptr, gnt, idx;
  logic          any;
  logic [CW-1:0] cnt;
  logic          expire, reject;
  logic [SW-1:0] sel_slave, lat_slave;
  logic [ZW-1:0] sel_size, lat_size;
  logic [1:0]    sel_mode, lat_mode;
  logic [DW-1:0] sel_data, lat_data;

  // Search starts at ptr and wraps, so the last winner has lowest priority.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      idx = RW'((int'(ptr) + k) % REQ_COUNT);
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
  end

  always_comb begin
    sel_slave = '0;
    sel_size  = '0;
    sel_mode  = '0;
    sel_data  = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (gnt == RW'(i)) begin
        sel_slave = req_slave[i*SW +: SW];
        sel_size  = req_size[i*ZW +: ZW];
        sel_mode  = req_mode[i*2 +: 2];
        sel_data  = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any && !areset) req_ready[gnt] = 1'b1;
  end

  assign reject = (sel_size == '0) || (int'(sel_size) > MAX_PACKAGE_SIZE) ||
                  (int'(sel_slave) >= SLAVE_COUNT);
  assign expire     = (cnt == CW'(TIMEOUT_CYCLES - 1));
  // Start waits for an idle core; done on the expiry cycle beats the abort.
  assign core_start = (state == START) && !core_busy;
  assign core_abort = (state == WAIT) && expire && !core_done;
  assign busy       = (state != IDLE);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      grant_id     <= '0;
      lat_slave    <= '0;
      lat_size     <= '0;
      lat_mode     <= '0;
      lat_data     <= '0;
      core_slave   <= '0;
      core_size    <= '0;
      core_mode    <= '0;
      core_tx_data <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          lat_slave <= sel_slave;
          lat_size  <= sel_size;
          lat_mode  <= sel_mode;
          lat_data  <= sel_data;
          grant_id  <= gnt;
          ptr       <= (gnt == RW'(REQ_COUNT - 1)) ? '0 : gnt + 1'b1;
          if (reject) begin
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_valid <= REQ_COUNT'(1) << gnt;
            state     <= RESP;
          end else begin
            state <= SETUP;
          end
        end
        SETUP: begin
          core_slave   <= lat_slave;
          core_size    <= lat_size;
          core_mode    <= lat_mode;
          core_tx_data <= lat_data;
          state        <= START;
        end
        START: if (!core_busy) begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (core_done) begin
            rsp_data  <= core_rx_data;
            rsp_err   <= 1'b0;
            rsp_valid <= REQ_COUNT'(1) << grant_id;
            state     <= RESP;
          end else if (expire) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= REQ_COUNT'(1) << grant_id;
            state     <= RESP;
          end
        end
        RESP: if (rsp_ready[grant_id]) begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one SPI master core between REQ_COUNT on-chip requesters using round-robin arbitration.
- Each granted request is one complete SPI transaction: slave index, package size, SPI mode and TX data.
- The block configures the core, starts it, waits for completion under a watchdog, then returns RX data and status to the winning requester.
- Sits between the AXI/AXIS-facing front ends and the SPI master core.

Parameters:
- REQ_COUNT, 4, number of requesters (>=2).
- SLAVE_COUNT, 1, number of SPI chip selects on the core.
- MAX_PACKAGE_SIZE, 8, maximum transaction length in bytes.
- TIMEOUT_CYCLES, 4096, aclk cycles allowed between core start and core_done.
- Derived: DW = 8*MAX_PACKAGE_SIZE; SW = max(1, clog2(SLAVE_COUNT)); ZW = clog2(MAX_PACKAGE_SIZE+1); RW = max(1, clog2(REQ_COUNT)).

Ports:
- aclk  in  1  Single clock for the whole block. The block has one clock; reset is asynchronous and active-high.
- areset  in  1  Asynchronous, active-high reset.
- req_valid  in  REQ_COUNT  Per-requester request valid.
- req_ready  out  REQ_COUNT  Per-requester accept; at most one bit high.
- req_slave  in  REQ_COUNT*SW  Packed slave index, requester i at [i*SW +: SW].
- req_size  in  REQ_COUNT*ZW  Packed byte count.
- req_mode  in  REQ_COUNT*2  Packed {CPOL,CPHA}.
- req_data  in  REQ_COUNT*DW  Packed TX data; byte 0 at LSB.
- rsp_valid  out  REQ_COUNT  Response valid, one-hot.
- rsp_ready  in  REQ_COUNT  Response accept.
- rsp_data  out  DW  RX data, shared by all requesters.
- rsp_err  out  1  1 = rejected or timed out.
- core_slave  out  SW  Chip-select index to the core.
- core_size  out  ZW  Byte count to the core.
- core_mode  out  2  {CPOL,CPHA} to the core.
- core_tx_data  out  DW  TX data to the core.
- core_start  out  1  One-cycle start pulse.
- core_abort  out  1  One-cycle abort pulse.
- core_busy  in  1  Core is transferring.
- core_done  in  1  One-cycle completion pulse.
- core_rx_data  in  DW  RX data from the core, valid with core_done.
- busy  out  1  High in any state other than IDLE.
- grant_id  out  RW  Index of the current or last granted requester.

Behaviour:
- Reset values: every output 0; round-robin pointer ptr = 0; state = IDLE; watchdog counter = 0.
- State sequence: IDLE -> SETUP -> START -> WAIT -> RESP -> IDLE; a rejected request goes IDLE -> RESP.
- IDLE, arbitration:
  - g = first i with req_valid[i], searching ptr, ptr+1, ... modulo REQ_COUNT.
  - req_ready = onehot(g), combinational, only in IDLE with any req_valid.
  - On the handshake cycle: latch slave/size/mode/data of g, set grant_id = g, set ptr = (g+1) mod REQ_COUNT.
- Rejection:
  - Conditions: size == 0, size > MAX_PACKAGE_SIZE, or slave >= SLAVE_COUNT.
  - Next state is RESP with rsp_err = 1 and rsp_data = 0; the core is never touched.
- SETUP (1 cycle): core_slave, core_size, core_mode, core_tx_data are registered from the latch and held stable until the block returns to IDLE.
- START:
  - Assert core_start for exactly one cycle, on the first cycle in START where core_busy == 0, then go to WAIT.
  - Core already busy: stay in START, core_start = 0.
- WAIT: counter increments every cycle from 0.
  - core_done: capture core_rx_data into rsp_data, rsp_err = 0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no core_done: pulse core_abort for 1 cycle, rsp_err = 1, rsp_data = 0, go to RESP.
  - core_done on the same cycle as expiry: done wins, no abort.
- RESP:
  - rsp_valid[grant_id] = 1; rsp_data and rsp_err held stable until rsp_ready[grant_id].
  - On the handshake cycle rsp_valid drops and the state goes to IDLE; the next grant is possible on the following cycle.
  - rsp_ready bits of other requesters are ignored.
- core_done outside WAIT is ignored.
- req_valid changes outside IDLE are ignored; requesters keep valid high until ready.
- Minimum latency, accepted request: request handshake at T, core_start at T+2, rsp_valid at D+1 where D is the core_done cycle.
- Mid-operation areset: immediate return to reset values; no abort pulse (the core shares the reset); ptr = 0.

Test Plan:
- Single request: REQ_COUNT=4, req 2: slave 0, size 2, mode 01, data 0xA55A; core returns 0x1234 six cycles after start -> core_start at T+2; core_size = 2, core_mode = 01; rsp_valid = 0100; rsp_data = 0x1234; rsp_err = 0.
- Fairness: req_valid = 1111 held continuously -> grant order 0,1,2,3,0; each req_ready is one cycle long.
- Rejects: size 0, size 9, slave 1 with SLAVE_COUNT=1 -> rsp_err = 1, rsp_data = 0; core_start never asserted; ptr still advances.
- Timeout: TIMEOUT_CYCLES=16, core never signals done -> core_abort pulses 16 cycles after start; rsp_err = 1.
- Done vs expiry: core_done on the expiry cycle -> rsp_err = 0; no core_abort.
- Busy core and backpressure: core_busy = 1 for 5 cycles in START -> core_start delayed until busy falls. Hold rsp_ready = 0 for 10 cycles -> rsp_valid, rsp_data and rsp_err stable; no new req_ready. Assert areset while in WAIT -> all outputs 0 the same cycle; next grant goes to requester 0.
